// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back
// for six instruction classes and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int unsigned        OPCD_W   = 6,
  parameter logic [OPCD_W-1:0]  OP_RTYPE = OPCD_W'(6'b000000),
  parameter logic [OPCD_W-1:0]  OP_LW    = OPCD_W'(6'b100011),
  parameter logic [OPCD_W-1:0]  OP_SW    = OPCD_W'(6'b101011),
  parameter logic [OPCD_W-1:0]  OP_BEQ   = OPCD_W'(6'b000100),
  parameter logic [OPCD_W-1:0]  OP_ADDI  = OPCD_W'(6'b001000),
  parameter logic [OPCD_W-1:0]  OP_J     = OPCD_W'(6'b000010),
  parameter int unsigned        CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPCD_W-1:0] i_opcd,
  input  logic              i_zero,
  input  logic              i_mem_rdy,
  output logic              o_ir_e,
  output logic              o_pc_e,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic              o_iord,
  output logic              o_reg_we,
  output logic              o_regdst,
  output logic              o_mem2reg,
  output logic              o_alu_srca,
  output logic [1:0]        o_alu_srcb,
  output logic [1:0]        o_alu_op,
  output logic [1:0]        o_pc_src,
  output logic              o_illegal,
  output logic [3:0]        o_state,
  output logic [CNT_W-1:0]  o_instret
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC    = 4'd6,
    ALU_WB  = 4'd7,
    BRANCH  = 4'd8,
    ADDI_EX = 4'd9,
    ADDI_WB = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t state;
  state_t next_state;
  logic   retire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // Next-state and control decode; everything is forced low while in reset
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    o_ir_e     = 1'b0;
    o_pc_e     = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_we   = 1'b0;
    o_iord     = 1'b0;
    o_reg_we   = 1'b0;
    o_regdst   = 1'b0;
    o_mem2reg  = 1'b0;
    o_alu_srca = 1'b0;
    o_alu_srcb = 2'b00;
    o_alu_op   = 2'b00;
    o_pc_src   = 2'b00;
    o_illegal  = 1'b0;

    if (rst) begin
      next_state = FETCH;
    end else begin
      case (state)
        FETCH: begin
          o_mem_re   = 1'b1;
          o_alu_srcb = 2'b01;
          if (i_mem_rdy) begin
            o_ir_e     = 1'b1;
            o_pc_e     = 1'b1;
            next_state = DECODE;
          end
        end
        DECODE: begin
          // ALU precomputes the branch target while the opcode is decoded
          o_alu_srcb = 2'b11;
          if (i_opcd == OP_LW || i_opcd == OP_SW) next_state = MEM_ADR;
          else if (i_opcd == OP_RTYPE)            next_state = EXEC;
          else if (i_opcd == OP_BEQ)              next_state = BRANCH;
          else if (i_opcd == OP_ADDI)             next_state = ADDI_EX;
          else if (i_opcd == OP_J)                next_state = JUMP;
          else begin
            o_illegal  = 1'b1;
            next_state = FETCH;
          end
        end
        MEM_ADR: begin
          o_alu_srca = 1'b1;
          o_alu_srcb = 2'b10;
          next_state = (i_opcd == OP_SW) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          o_mem_re = 1'b1;
          o_iord   = 1'b1;
          if (i_mem_rdy) next_state = MEM_WB;
        end
        MEM_WB: begin
          o_reg_we   = 1'b1;
          o_mem2reg  = 1'b1;
          retire     = 1'b1;
          next_state = FETCH;
        end
        MEM_WR: begin
          o_mem_we = 1'b1;
          o_iord   = 1'b1;
          if (i_mem_rdy) begin
            retire     = 1'b1;
            next_state = FETCH;
          end
        end
        EXEC: begin
          o_alu_srca = 1'b1;
          o_alu_op   = 2'b10;
          next_state = ALU_WB;
        end
        ALU_WB: begin
          o_reg_we   = 1'b1;
          o_regdst   = 1'b1;
          retire     = 1'b1;
          next_state = FETCH;
        end
        BRANCH: begin
          o_alu_srca = 1'b1;
          o_alu_op   = 2'b01;
          o_pc_src   = 2'b01;
          o_pc_e     = i_zero;
          retire     = 1'b1;
          next_state = FETCH;
        end
        ADDI_EX: begin
          o_alu_srca = 1'b1;
          o_alu_srcb = 2'b10;
          next_state = ADDI_WB;
        end
        ADDI_WB: begin
          o_reg_we   = 1'b1;
          retire     = 1'b1;
          next_state = FETCH;
        end
        JUMP: begin
          o_pc_src   = 2'b10;
          o_pc_e     = 1'b1;
          retire     = 1'b1;
          next_state = FETCH;
        end
        default: next_state = FETCH;
      endcase
    end
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         o_instret <= '0;
    else if (retire) o_instret <= o_instret + CNT_W'(1);
  end

  assign o_state = STATE_W'(state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each driven cycle queues its expected
// state/control/count, and a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

  localparam int unsigned OPCD_W = 6;
  localparam int unsigned CNT_W  = 4;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] BAD   = 6'b111111;

  // Control word: {ir,pc,re,we,iord,rw,rd,m2r,sa,sb[1:0],op[1:0],ps[1:0],ill}
  localparam logic [15:0] C_IR   = 16'h8000;
  localparam logic [15:0] C_PC   = 16'h4000;
  localparam logic [15:0] C_RE   = 16'h2000;
  localparam logic [15:0] C_WE   = 16'h1000;
  localparam logic [15:0] C_IORD = 16'h0800;
  localparam logic [15:0] C_RW   = 16'h0400;
  localparam logic [15:0] C_RD   = 16'h0200;
  localparam logic [15:0] C_M2R  = 16'h0100;
  localparam logic [15:0] C_SA   = 16'h0080;
  localparam logic [15:0] SB01   = 16'h0020;
  localparam logic [15:0] SB10   = 16'h0040;
  localparam logic [15:0] SB11   = 16'h0060;
  localparam logic [15:0] OP01   = 16'h0008;
  localparam logic [15:0] OP10   = 16'h0010;
  localparam logic [15:0] PS01   = 16'h0002;
  localparam logic [15:0] PS10   = 16'h0004;
  localparam logic [15:0] C_ILL  = 16'h0001;

  localparam logic [15:0] F_WAIT = C_RE | SB01;
  localparam logic [15:0] F_RDY  = C_IR | C_PC | C_RE | SB01;

  typedef struct packed {
    logic [3:0]       st;
    logic [15:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [OPCD_W-1:0] opcd;
  logic              zero;
  logic              mem_rdy;
  logic              ir_e, pc_e, mem_re, mem_we, iord, reg_we, regdst, mem2reg;
  logic              alu_srca, illegal;
  logic [1:0]        alu_srcb, alu_op, pc_src;
  logic [3:0]        state;
  logic [CNT_W-1:0]  instret;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks;
  int               n_pass;

  mc_ctrl_fsm #(.OPCD_W(OPCD_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_opcd     (opcd),
    .i_zero     (zero),
    .i_mem_rdy  (mem_rdy),
    .o_ir_e     (ir_e),
    .o_pc_e     (pc_e),
    .o_mem_re   (mem_re),
    .o_mem_we   (mem_we),
    .o_iord     (iord),
    .o_reg_we   (reg_we),
    .o_regdst   (regdst),
    .o_mem2reg  (mem2reg),
    .o_alu_srca (alu_srca),
    .o_alu_srcb (alu_srcb),
    .o_alu_op   (alu_op),
    .o_pc_src   (pc_src),
    .o_illegal  (illegal),
    .o_state    (state),
    .o_instret  (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] ctl;
      e   = sb.pop_front();
      ctl = {ir_e, pc_e, mem_re, mem_we, iord, reg_we, regdst, mem2reg,
             alu_srca, alu_srcb, alu_op, pc_src, illegal};
      check("state",   32'(state),   32'(e.st));
      check("ctl",     32'(ctl),     32'(e.ctl));
      check("instret", 32'(instret), 32'(e.cnt));
    end
  end

  // Drive one cycle's inputs and queue what the DUT must show before the next edge
  task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] ctl, input logic ret);
    exp_t e;
    rst = r; opcd = op; zero = z; mem_rdy = rdy;
    if (r) exp_cnt = '0;
    e.st = st; e.ctl = ctl; e.cnt = exp_cnt;
    sb.push_back(e);
    if (ret) exp_cnt = exp_cnt + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_lw();
    cyc(0, LW, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, LW, 0, 1, 4'd1, SB11, 0);
    cyc(0, LW, 0, 1, 4'd2, C_SA | SB10, 0);
    cyc(0, LW, 0, 1, 4'd3, C_RE | C_IORD, 0);
    cyc(0, LW, 0, 1, 4'd4, C_RW | C_M2R, 1);
  endtask

  task automatic do_rtype();
    cyc(0, RTYPE, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, RTYPE, 0, 1, 4'd1, SB11, 0);
    cyc(0, RTYPE, 0, 1, 4'd6, C_SA | OP10, 0);
    cyc(0, RTYPE, 0, 1, 4'd7, C_RW | C_RD, 1);
  endtask

  task automatic do_beq(input logic z);
    cyc(0, BEQ, z, 1, 4'd0, F_RDY, 0);
    cyc(0, BEQ, z, 1, 4'd1, SB11, 0);
    cyc(0, BEQ, z, 1, 4'd8, (z ? C_PC : 16'h0) | C_SA | OP01 | PS01, 1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = '0;
    rst = 1'b1; opcd = '0; zero = 1'b0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;

    cyc(1, LW, 0, 1, 4'd0, 16'h0, 0);                 // reset: all low
    do_lw();

    // SW: FETCH waits once, MEM_WR waits three cycles with mem_we held
    cyc(0, SW, 0, 0, 4'd0, F_WAIT, 0);
    cyc(0, SW, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, SW, 0, 0, 4'd1, SB11, 0);
    cyc(0, SW, 0, 0, 4'd2, C_SA | SB10, 0);
    for (int i = 0; i < 3; i++) cyc(0, SW, 0, 0, 4'd5, C_WE | C_IORD, 0);
    cyc(0, SW, 0, 1, 4'd5, C_WE | C_IORD, 1);

    do_beq(1'b1);
    do_beq(1'b0);

    // Illegal opcode: one pulse in DECODE, back to FETCH, no retire
    cyc(0, BAD, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, BAD, 0, 1, 4'd1, SB11 | C_ILL, 0);
    cyc(0, BAD, 0, 0, 4'd0, F_WAIT, 0);

    // ADDI
    cyc(0, ADDI, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, ADDI, 0, 1, 4'd1, SB11, 0);
    cyc(0, ADDI, 0, 1, 4'd9, C_SA | SB10, 0);
    cyc(0, ADDI, 0, 1, 4'd10, C_RW, 1);

    // J
    cyc(0, JMP, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, JMP, 0, 1, 4'd1, SB11, 0);
    cyc(0, JMP, 0, 1, 4'd11, C_PC | PS10, 1);

    // Reset while stalled in MEM_RD
    cyc(0, LW, 0, 1, 4'd0, F_RDY, 0);
    cyc(0, LW, 0, 1, 4'd1, SB11, 0);
    cyc(0, LW, 0, 0, 4'd2, C_SA | SB10, 0);
    cyc(0, LW, 0, 0, 4'd3, C_RE | C_IORD, 0);
    cyc(1, LW, 0, 1, 4'd0, 16'h0, 0);
    do_lw();

    // Counter wrap through 15 -> 0
    for (int i = 0; i < 16; i++) do_rtype();
    cyc(0, RTYPE, 0, 0, 4'd0, F_WAIT, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Full multicycle control unit for the RISC processor datapath. It sequences fetch, decode, address compute, memory, execute and write-back for six instruction classes, and drives all datapath enables and mux selects. It stalls on a memory-ready handshake and counts retired instructions. It sits between the instruction register (opcode source) and the datapath/memory interface.

Parameters:
OPCD_W, 6, opcode width in bits (must be >= 1)
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
i_opcd  in  OPCD_W  opcode from IR; stable from DECODE until the next FETCH
i_zero  in  1  ALU zero flag
i_mem_rdy  in  1  memory access completes this cycle
o_ir_e  out  1  IR write enable
o_pc_e  out  1  PC write enable (includes the branch-taken term)
o_mem_re  out  1  memory read request
o_mem_we  out  1  memory write request
o_iord  out  1  memory address select: 0=PC, 1=ALUOut
o_reg_we  out  1  register file write enable
o_regdst  out  1  write register: 0=rt, 1=rd
o_mem2reg  out  1  write data: 0=ALUOut, 1=MDR
o_alu_srca  out  1  ALU A: 0=PC, 1=rs
o_alu_srcb  out  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
o_alu_op  out  2  00=add, 01=sub, 10=funct-decoded
o_pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
o_illegal  out  1  one-cycle pulse: unrecognised opcode in DECODE
o_state  out  4  current state encoding (debug)
o_instret  out  CNT_W  retired-instruction count

Behaviour:
- State register, 4 bits, async reset to FETCH. Encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11. Encodings 12-15 are illegal and go to FETCH on the next edge.
- While rst is high, every enable output (o_ir_e, o_pc_e, o_mem_re, o_mem_we, o_reg_we, o_illegal) is 0, o_state=0, o_instret=0, and all selects are 0.
- FETCH: o_mem_re=1, iord=0, srca=0, srcb=01, alu_op=00, pc_src=00.
  - If i_mem_rdy=1: o_ir_e=1, o_pc_e=1, next state DECODE.
  - Otherwise all enables other than mem_re stay 0 and the state holds.
- DECODE: srca=0, srcb=11, alu_op=00 (precompute branch target). Next state by i_opcd:
  - LW/SW -> MEM_ADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDI_EX
  - J -> JUMP
  - anything else -> FETCH, with o_illegal=1 for that cycle.
- MEM_ADR: srca=1, srcb=10, alu_op=00. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_re=1, iord=1. Holds until i_mem_rdy, then MEM_WB.
- MEM_WB: reg_we=1, regdst=0, mem2reg=1. Next state FETCH; retires.
- MEM_WR: mem_we=1, iord=1. Holds until i_mem_rdy; mem_we stays asserted while waiting. Then FETCH; retires on the ready cycle.
- EXEC: srca=1, srcb=00, alu_op=10. Next state ALU_WB.
- ALU_WB: reg_we=1, regdst=1, mem2reg=0. Next state FETCH; retires.
- BRANCH: srca=1, srcb=00, alu_op=01, pc_src=01, o_pc_e=i_zero. Next state FETCH; retires whether or not the branch is taken.
- ADDI_EX: srca=1, srcb=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_we=1, regdst=0, mem2reg=0. Next state FETCH; retires.
- JUMP: pc_src=10, o_pc_e=1. Next state FETCH; retires.
- Outputs not listed for a state are 0.
- Outputs are a combinational decode of the state plus i_mem_rdy/i_zero (Moore, plus Mealy gating on handshake inputs only).
- Latency, in cycles with i_mem_rdy=1 throughout: LW=5, SW=4, R-type=4, ADDI=4, BEQ=3, J=3.
- o_instret increments by 1 on each retiring edge and wraps modulo 2^CNT_W with no flag.
- Reset asserted mid-instruction: returns to FETCH immediately; no partial write enable is held; the counter clears.
- i_mem_rdy outside FETCH/MEM_RD/MEM_WR is ignored.

Test Plan:
- LW opcode 100011, i_mem_rdy=1 -> states 0,1,2,3,4,0. reg_we and mem2reg high only in state 4. o_instret 0->1.
- SW with i_mem_rdy low for 3 cycles in MEM_WR -> o_mem_we held high 4 cycles, state stays 5, then FETCH, o_instret+1.
- BEQ with i_zero=1, then again with i_zero=0 -> o_pc_e=1 with pc_src=01 in the first case; o_pc_e=0 in the second; both retire.
- Opcode 111111 -> o_illegal pulses exactly once in DECODE, next state FETCH, o_instret unchanged.
- rst asserted while in MEM_RD -> o_state=0, all enables 0 immediately; after release, FETCH behaves normally.
- CNT_W=4, 16 R-type instructions -> o_instret wraps 15->0.
